// File: rtl/inst_sram_axi_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like instruction port to an
// AXI read channel pair: one single-beat AR per accepted request, in-order R.
module inst_sram_axi_bridge #(
    parameter logic [3:0]  ARID            = 4'd0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    ar_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  arsize_q, arsize_d;
    logic        data_ok_q;
    logic [31:0] rdata_q;

    logic addr_ok;
    logic ar_valid;
    logic r_hs;
    logic unused_r;

    // ID, response code and last flag carry no information for single-ID,
    // single-beat reads whose data is returned regardless of outcome.
    assign unused_r = ^{rid, rresp, rlast};

    assign rready = (cnt_q != 3'd0);
    assign r_hs   = rvalid & rready;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arsize_d = arsize_q;
        addr_ok  = 1'b0;
        ar_valid = 1'b0;
        case (state_q)
            AR_IDLE: begin
                addr_ok = inst_sram_en & ~inst_sram_wr & (cnt_q < MaxCnt);
                if (addr_ok) begin
                    araddr_d = inst_sram_addr;
                    arsize_d = inst_sram_size;
                    state_d  = AR_BUSY;
                end
            end
            AR_BUSY: begin
                ar_valid = 1'b1;
                if (arready) begin
                    state_d = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({addr_ok, r_hs})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= AR_IDLE;
            cnt_q     <= 3'd0;
            araddr_q  <= 32'd0;
            arsize_q  <= 2'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            data_ok_q <= r_hs;
            if (r_hs) begin
                rdata_q <= rdata;
            end
        end
    end

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;

    assign arid    = ARID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = ar_valid;

endmodule

// File: doc/inst_sram_axi_bridge.md
# inst_sram_axi_bridge

Read-only bridge between the fetch stage's SRAM-like instruction port and an AXI3/AXI4 read master channel pair. It sits directly downstream of the fetch stage's `inst_sram_*` outputs. Each request accepted with `addr_ok` is converted into a single-beat AXI read (AR). Each R beat is returned in order as a registered `data_ok`/`rdata` pulse. Up to `MAX_OUTSTANDING` reads may be in flight. There is no data-side back-pressure, because the fetch stage buffers returned words itself.

## Interface

Parameters:
- `ARID`, default 0: constant AXI ID driven on `arid` (4 bits). Responses are in order under this single ID.
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unreturned reads. Legal range 1..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `inst_sram_en`  in  1  fetch request valid.
- `inst_sram_wr`  in  1  write flag; a request with this bit set is never accepted.
- `inst_sram_size`  in  2  transfer size (log2 bytes), forwarded to `arsize`.
- `inst_sram_addr`  in  32  fetch physical address.
- `inst_sram_addr_ok`  out  1  request accepted this cycle (combinational).
- `inst_sram_data_ok`  out  1  returned word valid (registered).
- `inst_sram_rdata`  out  32  returned word (registered).
- `arid`  out  4  = `ARID`.
- `araddr`  out  32  latched request address.
- `arlen`  out  8  = 0 (single beat).
- `arsize`  out  3  = {1'b0, latched size}.
- `arburst`  out  2  = 2'b01.
- `arlock`  out  2  = 0.
- `arcache`  out  4  = 0.
- `arprot`  out  3  = 0.
- `arvalid`  out  1  AR valid.
- `arready`  in  1  AR ready.
- `rid`  in  4  ignored.
- `rdata`  in  32  read data.
- `rresp`  in  2  ignored; data is returned regardless of response code.
- `rlast`  in  1  ignored (single beat).
- `rvalid`  in  1  R valid.
- `rready`  out  1  R ready.

## Operation

- **AR FSM, two states.**
  - `AR_IDLE`: `arvalid`=0.
    - `inst_sram_addr_ok` = `inst_sram_en` & ~`inst_sram_wr` & (`cnt` < `MAX_OUTSTANDING`).
    - When `addr_ok`=1: latch the address and size, go to `AR_BUSY`.
  - `AR_BUSY`: `arvalid`=1 and `addr_ok`=0.
    - `araddr`/`arsize` are held stable.
    - On `arvalid`&`arready`: return to `AR_IDLE`.
- **Outstanding counter `cnt`** (3 bits).
  - +1 on an `addr_ok` cycle; −1 on an `rvalid`&`rready` cycle.
  - Both in the same cycle: `cnt` is unchanged.
  - The `addr_ok` condition samples `cnt` before that cycle's update.
  - `cnt` never exceeds `MAX_OUTSTANDING` and never underflows.
- **R path.**
  - `rready` = (`cnt` != 0).
  - On an R handshake, register `rdata` into `inst_sram_rdata` and set `inst_sram_data_ok`=1 for exactly the next cycle.
  - `inst_sram_data_ok` otherwise returns to 0. `inst_sram_rdata` holds its last value.
- **Stray R beat** (`rvalid` while `cnt`=0): not accepted (`rready`=0) and no `data_ok`.
- **Cancellation** is the fetch stage's responsibility. The bridge returns every accepted read, in order.
- **Writes** (`inst_sram_wr`=1) are held off indefinitely. The fetch stage ties `inst_sram_wr` to 0.
- **Reset (async, `resetn`=0)**, taking effect immediately, including mid-transaction:
  - FSM goes to `AR_IDLE`; `cnt` = 0.
  - `arvalid`=0, `rready`=0, `inst_sram_data_ok`=0, `inst_sram_rdata`=0, `araddr`=0, `arsize`=0.
  - Any in-flight AXI transaction is abandoned. The system resets the slave together with this block.

## Timing

- Request accepted at cycle T: `arvalid` is high from T+1 until the first cycle arready=1 is sampled.
- Earliest next `addr_ok`: the cycle after the AR handshake. Peak issue rate is one request per 2 cycles with a zero-wait slave.
- R handshake at cycle R: `data_ok`=1 and `rdata` valid during R+1.
- Zero-wait slave (arready and rvalid asserted as early as permitted): `addr_ok` at T, AR handshake at T+1, R handshake at T+2, `data_ok` at T+3.
- With `cnt`=`MAX_OUTSTANDING` and an R handshake in the same cycle, `addr_ok` stays 0 that cycle and is allowed the following cycle.
- Back-to-back R beats on consecutive cycles produce `data_ok` on consecutive cycles.

## Test plan

- **Reset:** assert `resetn`=0 mid-`AR_BUSY`.
  - Expect `arvalid`=0, `data_ok`=0 and `rdata`=0 immediately.
  - After release, a request to 0x1C000000 is accepted on the first cycle `en`=1.
- **Single read, zero-wait slave:** `en`=1, addr 0x1C000000, slave returns 0x02800C0C.
  - Expect `addr_ok` at T, `arvalid`/`araddr`=0x1C000000 at T+1, `arsize`=2.
  - Expect `data_ok`=1 with `rdata`=0x02800C0C at T+3 only.
- **Outstanding limit (`MAX_OUTSTANDING`=2):** slave holds `rvalid`=0; continuous requests to 0x1C000000, 0x1C000004, 0x1C000008.
  - Expect exactly two AR handshakes; third `addr_ok` stays 0.
  - After the first R beat, the third is accepted the next cycle.
- **Ordering and back-to-back returns:** two R beats on consecutive cycles (0x11111111, 0x22222222).
  - Expect `data_ok` on two consecutive cycles with rdata in the same order.
- **AR back-pressure:** `arready`=0 for 5 cycles.
  - Expect `arvalid` held high and `araddr` stable for all 5 cycles, and `addr_ok`=0 throughout.
- **Error and stray responses:**
  - R beat with `rresp`=2'b10 still yields `data_ok` with its data.
  - `rvalid`=1 while `cnt`=0 gives `rready`=0 and no `data_ok`.
  - Request with `inst_sram_wr`=1 never gets `addr_ok`.
